axi4_lite_reg_bank: RTL
=======================

AXI4_LITE_REG_BANK -- requirements
Module: axi4_lite_reg_bank

Interface
REQ-001 SHALL have parameter ADDR_BIT_WIDTH, default 32, AXI4-Lite address width.
REQ-002 SHALL have parameter DATA_BIT_WIDTH, default 32, data width; legal values 32 or 64.
REQ-003 SHALL have parameter NUM_REGS, default 8, register count; range 1..256.
REQ-004 SHALL have parameter RO_MASK, default 0, NUM_REGS bits; bit k=1 makes register k read-only.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port i_clk  in  1  clock.
REQ-007 SHALL have port i_rst  in  1  reset (async assert, active-high).
REQ-008 SHALL have ports s_axi_awaddr/awvalid/awready  in/in/out  ADDR_BIT_WIDTH/1/1  write address channel.
REQ-009 SHALL have ports s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_BIT_WIDTH/DATA_BIT_WIDTH/8/1/1  write data channel.
REQ-010 SHALL have ports s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
REQ-011 SHALL have ports s_axi_araddr/arvalid/arready  in/in/out  ADDR_BIT_WIDTH/1/1  read address channel.
REQ-012 SHALL have ports s_axi_rdata/rresp/rvalid/rready  out/out/out/in  DATA_BIT_WIDTH/2/1/1  read data channel.
REQ-013 SHALL have port o_reg_vals  out  NUM_REGS*DATA_BIT_WIDTH  RW register contents; register k at slice k.
REQ-014 SHALL have port i_ro_vals  in  NUM_REGS*DATA_BIT_WIDTH  values returned for read-only registers.

Function
REQ-015 Decode: ADDR_LSB = log2(DATA_BIT_WIDTH/8). Index = addr >> ADDR_LSB. Bits below ADDR_LSB are ignored.
REQ-016 Index >= NUM_REGS SHALL yield DECERR, with no state change; this includes any nonzero upper address bits.
REQ-017 Write FSM states: W_IDLE and W_RESP.
- In W_IDLE, AW and W are captured independently, in either order or in the same cycle.
- awready is high while AW is not yet captured; wready is high while W is not yet captured.
REQ-018 When both AW and W are captured, the FSM SHALL update the register and enter W_RESP on the next cycle.
- bvalid rises one cycle after the later of the two handshakes.
REQ-019 The register update SHALL apply byte lane b only where wstrb[b]=1.
- Write to a RO register: SLVERR, register unchanged.
- In-range RW register: OKAY.
REQ-020 In W_RESP, bvalid SHALL stay high, with bresp stable, until bready.
- Then return to W_IDLE with both capture flags cleared.
- awready and wready are low throughout W_RESP.
REQ-021 Read FSM states: R_IDLE (arready=1) and R_RESP (arready=0).
- An AR handshake latches rdata/rresp; rvalid rises on the next cycle.
- rdata and rresp are held stable until rready, then the FSM returns to R_IDLE.
REQ-022 Read data sources:
- RO register: i_ro_vals slice sampled at the AR handshake.
- RW register: stored value.
- DECERR: rdata SHALL be 0.
REQ-023 A read and a write to the same register completing in the same cycle SHALL return the pre-write value.
REQ-024 The read and write paths SHALL operate concurrently with no mutual stalling; at most one transaction is outstanding per path.
REQ-025 EXOKAY SHALL never be issued.

Reset
REQ-026 Asserting i_rst SHALL asynchronously force the following, aborting any in-flight transaction without emitting a response:
- all registers to 0;
- both FSMs to IDLE with capture flags cleared;
- bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
REQ-027 The ready outputs awready, wready and arready SHALL be 1 in the first cycle after i_rst deasserts.

Structure
REQ-028 Shared package axi4_lite_pkg SHALL hold:
- axi4_resp_t (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11);
- the default address and data width localparams (32/32).
REQ-029 Address decode (index extraction, range check, RO lookup) SHALL be the sub-module axi4_lite_reg_decoder, instantiated once per path.

Verification
REQ-030 Reset, then AW 0x04 and W 0xDEADBEEF with wstrb 0xF in the same cycle -> bresp OKAY after 1 cycle; slice 1 = 0xDEADBEEF.
REQ-031 W 0x11223344 with wstrb 0x5 three cycles before AW 0x08 -> slice 2 = 0x00220044; awready stays high until the AW handshake.
REQ-032 With RO_MASK=0x01 and i_ro_vals slice0=0xCAFE0001: write 0x0 -> SLVERR, reg unchanged; read 0x0 -> 0xCAFE0001 OKAY.
REQ-033 NUM_REGS=8: write and read at 0x20 -> DECERR; rdata 0; o_reg_vals unchanged.
REQ-034 Hold bready and rready low for 5 cycles -> bvalid/rvalid and data stay stable; no new handshake accepted; simultaneous read/write to reg 3 returns the old value.
REQ-035 Assert i_rst during W_RESP -> bvalid falls immediately; all registers read 0 afterwards.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, default bus widths and
// small elaboration-time helpers used by the register bank and its decoder.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi4_resp_t;

  localparam int unsigned AXI_ADDR_WIDTH = 32;
  localparam int unsigned AXI_DATA_WIDTH = 32;

  // Byte-offset bits below the word index.
  function automatic int unsigned addr_lsb(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int unsigned reg_index_width(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/axi4_lite_reg_decoder.sv
// Address decode for the register bank: word index, range check and
// read-only lookup. Purely combinational; one instance per AXI path.
module axi4_lite_reg_decoder
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_BIT_WIDTH = AXI_ADDR_WIDTH,
  parameter int unsigned DATA_BIT_WIDTH = AXI_DATA_WIDTH,
  parameter int unsigned NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  localparam int unsigned IDX_W = reg_index_width(NUM_REGS)
) (
  input  logic [ADDR_BIT_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]          index,
  output logic                      in_range,
  output logic                      read_only
);

  localparam int unsigned ADDR_LSB = addr_lsb(DATA_BIT_WIDTH);

  logic [ADDR_BIT_WIDTH-1:0] word_addr;

  // The full shifted address is range-checked so any set upper bit decodes out.
  always_comb begin
    word_addr = addr >> ADDR_LSB;
    in_range  = (word_addr < ADDR_BIT_WIDTH'(NUM_REGS));
    index     = word_addr[IDX_W-1:0];
    read_only = 1'b0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (in_range && (index == IDX_W'(k))) read_only = RO_MASK[k];
    end
  end

endmodule

// File: rtl/axi4_lite_reg_bank.sv
// AXI4-Lite slave exposing NUM_REGS registers; RW registers are stored here,
// read-only registers return the live i_ro_vals slice captured at the AR handshake.
module axi4_lite_reg_bank
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_BIT_WIDTH = AXI_ADDR_WIDTH,
  parameter int unsigned DATA_BIT_WIDTH = AXI_DATA_WIDTH,
  parameter int unsigned NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [ADDR_BIT_WIDTH-1:0]           s_axi_awaddr,
  input  logic                                s_axi_awvalid,
  output logic                                s_axi_awready,
  input  logic [DATA_BIT_WIDTH-1:0]           s_axi_wdata,
  input  logic [DATA_BIT_WIDTH/8-1:0]         s_axi_wstrb,
  input  logic                                s_axi_wvalid,
  output logic                                s_axi_wready,
  output logic [1:0]                          s_axi_bresp,
  output logic                                s_axi_bvalid,
  input  logic                                s_axi_bready,
  input  logic [ADDR_BIT_WIDTH-1:0]           s_axi_araddr,
  input  logic                                s_axi_arvalid,
  output logic                                s_axi_arready,
  output logic [DATA_BIT_WIDTH-1:0]           s_axi_rdata,
  output logic [1:0]                          s_axi_rresp,
  output logic                                s_axi_rvalid,
  input  logic                                s_axi_rready,
  output logic [NUM_REGS*DATA_BIT_WIDTH-1:0]  o_reg_vals,
  input  logic [NUM_REGS*DATA_BIT_WIDTH-1:0]  i_ro_vals
);

  localparam int unsigned STRB_W = DATA_BIT_WIDTH / 8;
  localparam int unsigned IDX_W  = reg_index_width(NUM_REGS);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  logic [DATA_BIT_WIDTH-1:0] regs    [NUM_REGS];
  logic [DATA_BIT_WIDTH-1:0] ro_vals [NUM_REGS];

  // Write path state
  w_state_t                  w_state;
  logic                      aw_done;
  logic                      w_done;
  logic [ADDR_BIT_WIDTH-1:0] aw_addr_q;
  logic [DATA_BIT_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]         w_strb_q;
  axi4_resp_t                bresp_q;
  logic                      bvalid_q;

  logic                      aw_hs;
  logic                      w_hs;
  logic                      wr_fire;
  logic [ADDR_BIT_WIDTH-1:0] wr_addr;
  logic [DATA_BIT_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]         wr_strb;
  logic [IDX_W-1:0]          wr_idx;
  logic                      wr_in_range;
  logic                      wr_ro;

  // Read path state
  r_state_t                  r_state;
  axi4_resp_t                rresp_q;
  logic                      rvalid_q;
  logic [DATA_BIT_WIDTH-1:0] rdata_q;

  logic [IDX_W-1:0]          rd_idx;
  logic                      rd_in_range;
  logic                      rd_ro;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_slices
    assign o_reg_vals[k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = regs[k];
    assign ro_vals[k] = i_ro_vals[k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
  end

  assign s_axi_awready = (w_state == W_IDLE) && !aw_done;
  assign s_axi_wready  = (w_state == W_IDLE) && !w_done;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;

  assign s_axi_arready = (r_state == R_IDLE);
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;

  // Commit in the cycle of the later handshake, using the live channel
  // when it has not been captured yet, so bvalid follows one cycle later.
  assign wr_fire = (w_state == W_IDLE) && (aw_done || aw_hs) && (w_done || w_hs);
  assign wr_addr = aw_done ? aw_addr_q : s_axi_awaddr;
  assign wr_data = w_done ? w_data_q : s_axi_wdata;
  assign wr_strb = w_done ? w_strb_q : s_axi_wstrb;

  axi4_lite_reg_decoder #(
    .ADDR_BIT_WIDTH (ADDR_BIT_WIDTH),
    .DATA_BIT_WIDTH (DATA_BIT_WIDTH),
    .NUM_REGS       (NUM_REGS),
    .RO_MASK        (RO_MASK)
  ) u_wr_decoder (
    .addr      (wr_addr),
    .index     (wr_idx),
    .in_range  (wr_in_range),
    .read_only (wr_ro)
  );

  axi4_lite_reg_decoder #(
    .ADDR_BIT_WIDTH (ADDR_BIT_WIDTH),
    .DATA_BIT_WIDTH (DATA_BIT_WIDTH),
    .NUM_REGS       (NUM_REGS),
    .RO_MASK        (RO_MASK)
  ) u_rd_decoder (
    .addr      (s_axi_araddr),
    .index     (rd_idx),
    .in_range  (rd_in_range),
    .read_only (rd_ro)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      w_state   <= W_IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= OKAY;
      bvalid_q  <= 1'b0;
      for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_fire) begin
            if (wr_in_range && !wr_ro) begin
              for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
              end
            end
            bresp_q  <= !wr_in_range ? DECERR : (wr_ro ? SLVERR : OKAY);
            bvalid_q <= 1'b1;
            aw_done  <= 1'b1;
            w_done   <= 1'b1;
            w_state  <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_done   <= 1'b1;
              aw_addr_q <= s_axi_awaddr;
            end
            if (w_hs) begin
              w_done   <= 1'b1;
              w_data_q <= s_axi_wdata;
              w_strb_q <= s_axi_wstrb;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_q <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Reads sample regs before this edge's write lands, so a same-cycle
  // read of a register being written returns the old contents.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= R_IDLE;
      rresp_q  <= OKAY;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            if (!rd_in_range) begin
              rdata_q <= '0;
              rresp_q <= DECERR;
            end else if (rd_ro) begin
              rdata_q <= ro_vals[rd_idx];
              rresp_q <= OKAY;
            end else begin
              rdata_q <= regs[rd_idx];
              rresp_q <= OKAY;
            end
            rvalid_q <= 1'b1;
            r_state  <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_axi_rready) begin
            rvalid_q <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
      endcase
    end
  end

endmodule
